// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: owns the PC, issues one word fetch at a time, buffers
// {pc,instr} in a small FIFO toward decode, and drains stale responses.
// Ports: clock, reset (async, active-high); imem_req_valid/ready/addr out;
// imem_rsp_valid/data in; redirect_valid/pc in; dec_valid/ready/pc/instr.
// Optional build macro FETCH_BYPASS_EN: an accepted response bypasses an
// empty FIFO straight to decode when dec_ready is high in the same cycle.
module riscv_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [31:0]     dec_instr
);

    localparam int unsigned   PW      = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            run_q, run_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [XLEN-1:0] mem_pc_q [FIFO_DEPTH];
    logic [XLEN-1:0] mem_pc_d [FIFO_DEPTH];
    logic [31:0]     mem_ins_q [FIFO_DEPTH];
    logic [31:0]     mem_ins_d [FIFO_DEPTH];

    logic empty;
    logic req_fire;
    logic rsp_take;
    logic bypass;
    logic push;
    logic pop;

    // Handshakes and decode-side outputs.
    always_comb begin
        empty = (cnt_q == '0);
        // run_q holds requests off until the first edge after reset.
        // A request is only possible in FETCH, where nothing is owed,
        // so the issue credit reduces to a free FIFO slot.
        imem_req_valid = run_q && (state_q == S_FETCH)
                         && (cnt_q < DEPTH_C);
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_take       = (state_q == S_WAIT) && imem_rsp_valid
                         && !redirect_valid;
`ifdef FETCH_BYPASS_EN
        bypass    = rsp_take && empty && dec_ready;
        dec_valid = !empty || bypass;
        dec_pc    = bypass ? req_pc_q      : mem_pc_q[rd_q];
        dec_instr = bypass ? imem_rsp_data : mem_ins_q[rd_q];
`else
        bypass    = 1'b0;
        dec_valid = !empty;
        dec_pc    = mem_pc_q[rd_q];
        dec_instr = mem_ins_q[rd_q];
`endif
        push = rsp_take && !bypass;
        // A flush in the same cycle turns the pop into a no-op.
        pop  = !empty && dec_ready && !redirect_valid;
    end

    // Fetch FSM and PC.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        run_d    = 1'b1;
        unique case (state_q)
            S_FETCH: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = redirect_valid ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                // A response coinciding with a redirect is dropped via
                // rsp_take; either way the owed response has arrived.
                if (imem_rsp_valid) begin
                    state_d = S_FETCH;
                end else if (redirect_valid) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The stale response is swallowed here; a redirect in
                // the same cycle only retargets the PC.
                if (imem_rsp_valid) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc & ~XLEN'(3);
        end
    end

    // Output FIFO.
    always_comb begin
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        mem_pc_d  = mem_pc_q;
        mem_ins_d = mem_ins_q;
        if (redirect_valid) begin
            cnt_d = '0;
            wr_d  = '0;
            rd_d  = '0;
        end else begin
            if (push) begin
                mem_pc_d[wr_q]  = req_pc_q;
                mem_ins_d[wr_q] = imem_rsp_data;
                wr_d            = wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            run_q     <= 1'b0;
            cnt_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            mem_pc_q  <= '{default: '0};
            mem_ins_q <= '{default: '0};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            run_q     <= run_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            mem_pc_q  <= mem_pc_d;
            mem_ins_q <= mem_ins_d;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: directed scenarios plus a randomized run, checked
// against a program-order stream model and an in-order memory model.
module tb_riscv_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;

    riscv_fetch_unit #(
        .XLEN(32),
        .RESET_PC(RESET_PC),
        .FIFO_DEPTH(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .dec_valid(dec_valid),
        .dec_ready(dec_ready),
        .dec_pc(dec_pc),
        .dec_instr(dec_instr)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // knobs
    int ready_mode = 0;
    int dec_mode = 0;
    int lat_lo = 1;
    int lat_hi = 1;
    int redir_pct = 0;
    bit force_redir = 1'b0;
    logic [31:0] force_tgt = '0;

    // reference model state
    int          cyc_n = 0;
    bit          have_pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_due = 0;
    logic [31:0] fetch_exp = '0;
    logic [31:0] dec_exp = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    logic [31:0] req_log[$];
    logic [31:0] dec_log[$];
    int          dec_cyc[$];
    int          rsp_cyc[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] rq(input int i);
        return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] dq(input int i);
        return (i < dec_log.size()) ? dec_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int dcyc(input int i);
        return (i < dec_cyc.size()) ? dec_cyc[i] : -100;
    endfunction

    function automatic int rcyc(input int i);
        return (i < rsp_cyc.size()) ? rsp_cyc[i] : -200;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; leaves reset released at a falling edge.
    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        force_redir    = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        cyc_n = 0;
        have_pend = 1'b0;
        fetch_exp = RESET_PC;
        dec_exp = RESET_PC;
        prev_stall = 1'b0;
        req_log.delete();
        dec_log.delete();
        dec_cyc.delete();
        rsp_cyc.delete();
    endtask

    // One clock cycle: drive at the falling edge, observe 1 unit later.
    task automatic step();
        logic [31:0] tgt;
        imem_req_ready = (ready_mode == 0) ? 1'b1
                         : ($urandom_range(9) < 7);
        case (dec_mode)
            0: dec_ready = 1'b1;
            1: dec_ready = 1'b0;
            default: dec_ready = ($urandom_range(3) != 0);
        endcase
        redirect_valid = 1'b0;
        redirect_pc = $urandom();
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc = force_tgt;
            force_redir = 1'b0;
        end else if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
            redirect_valid = 1'b1;
            if ($urandom_range(3) == 0)
                redirect_pc = 32'hFFFF_FFF0 | $urandom_range(15);
        end
        imem_rsp_valid = have_pend && (cyc_n >= pend_due);
        imem_rsp_data = imem_rsp_valid ? instr_of(pend_addr) : $urandom();
        #1;
        if (prev_stall) begin
            chk("hold_valid", imem_req_valid, 1'b1);
            chk("hold_addr", imem_req_addr, prev_addr);
        end
        if (imem_rsp_valid) begin
            have_pend = 1'b0;
            rsp_cyc.push_back(cyc_n);
        end
        if (imem_req_valid && imem_req_ready) begin
            chk("one_outstanding", {31'b0, have_pend}, 32'h0);
            chk("req_addr", imem_req_addr, fetch_exp);
            req_log.push_back(imem_req_addr);
            have_pend = 1'b1;
            pend_addr = imem_req_addr;
            pend_due = cyc_n + $urandom_range(lat_hi, lat_lo);
            fetch_exp = fetch_exp + 32'd4;
        end
        if (dec_valid && dec_ready && !redirect_valid) begin
            chk("dec_pc", dec_pc, dec_exp);
            chk("dec_instr", dec_instr, instr_of(dec_exp));
            dec_log.push_back(dec_pc);
            dec_cyc.push_back(cyc_n);
            dec_exp = dec_exp + 32'd4;
        end
        if (redirect_valid) begin
            tgt = redirect_pc & 32'hFFFF_FFFC;
            fetch_exp = tgt;
            dec_exp = tgt;
        end
        prev_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_addr = imem_req_addr;
        @(posedge clock);
        @(negedge clock);
        cyc_n++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);

        // 1: straight-line fetch, 1-cycle memory, decode always ready
        do_reset();
        ready_mode = 0; dec_mode = 0; lat_lo = 1; lat_hi = 1; redir_pct = 0;
        repeat (10) step();
        chk("t1_req0", rq(0), 32'h0);
        chk("t1_req1", rq(1), 32'h4);
        chk("t1_req2", rq(2), 32'h8);
        chk("t1_dec0", dq(0), 32'h0);
        chk("t1_dec1", dq(1), 32'h4);
        chk("t1_dec2", dq(2), 32'h8);
        for (int i = 0; i < 3; i++)
            chk("t1_latency", dcyc(i), rcyc(i) + LAT);

        // 2: decode stalled, FIFO fills and issue stops
        do_reset();
        dec_mode = 1;
        repeat (12) step();
        chk("t2_nreq", req_log.size(), 2);
        chk("t2_req_valid_off", imem_req_valid, 1'b0);
        chk("t2_dec_valid", dec_valid, 1'b1);
        chk("t2_head_pc", dec_pc, 32'h0);
        dec_mode = 0;
        repeat (10) step();
        chk("t2_dec0", dq(0), 32'h0);
        chk("t2_dec1", dq(1), 32'h4);
        chk("t2_dec2", dq(2), 32'h8);
        chk("t2_back2back", dcyc(1), dcyc(0) + 1);
        chk("t2_resume", rq(2), 32'h8);

        // 3: redirect in WAIT, stale response two cycles later
        do_reset();
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 20 && req_log.size() == 0; i++) step();
        chk("t3_first_req", req_log.size(), 1);
        force_redir = 1'b1; force_tgt = 32'h100;
        step();
        lat_lo = 1; lat_hi = 1;
        repeat (12) step();
        chk("t3_next_req", rq(1), 32'h100);
        chk("t3_dec0", dq(0), 32'h100);

        // 4: redirect to a misaligned target alongside the response
        do_reset();
        lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 20 && req_log.size() == 0; i++) step();
        chk("t4_first_req", req_log.size(), 1);
        step();
        force_redir = 1'b1; force_tgt = 32'h203;
        step();
        lat_lo = 1; lat_hi = 1;
        repeat (10) step();
        chk("t4_next_req", rq(1), 32'h200);
        chk("t4_dec0", dq(0), 32'h200);

        // 5: reset mid-WAIT with one entry buffered
        do_reset();
        dec_mode = 1; lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 30 && req_log.size() < 2; i++) step();
        chk("t5_second_req", req_log.size(), 2);
        chk("t5_one_buffered", dec_valid, 1'b1);
        do_reset();
        dec_mode = 0; lat_lo = 1; lat_hi = 1;
        repeat (6) step();
        chk("t5_first_req", rq(0), RESET_PC);

        // 6: PC wrap-around
        do_reset();
        force_redir = 1'b1; force_tgt = 32'hFFFF_FFFC;
        repeat (10) step();
        chk("t6_req0", rq(0), 32'hFFFF_FFFC);
        chk("t6_req1", rq(1), 32'h0000_0000);
        chk("t6_dec1", dq(1), 32'h0000_0000);

        // 7: randomized traffic, backpressure and redirects
        do_reset();
        ready_mode = 1; dec_mode = 2; lat_lo = 1; lat_hi = 4; redir_pct = 4;
        repeat (3000) step();
        chk("t7_progress", (dec_log.size() > 100), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
- Instruction fetch stage of the RISC-V core; sits directly upstream of the IF/ID resettable pipeline register and feeds it.
- Owns the program counter and issues word fetches to instruction memory over a valid/ready request channel.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects, including discarding a stale in-flight response.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, {pc,instr} output buffer entries (power of two, >=2).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; at least 1 cycle after acceptance, in order.
- imem_rsp_data  in  32  fetched instruction.
- redirect_valid  in  1  taken branch/jump/trap redirect.
- redirect_pc  in  XLEN  redirect target.
- dec_valid  out  1  instruction available to decode.
- dec_ready  in  1  decode consumes the entry.
- dec_pc  out  XLEN  PC of the presented instruction.
- dec_instr  out  32  presented instruction.

Behaviour:
- Reset (async assert, released synchronously by the next clock edge):
  - pc = RESET_PC, state = FETCH, FIFO empty, outstanding = 0.
  - imem_req_valid = 0, dec_valid = 0, dec_pc = 0, dec_instr = 0.
- FSM states: FETCH, WAIT, DRAIN. At most one request outstanding.
- FETCH:
  - imem_req_valid = 1 when (fifo_count + outstanding) < FIFO_DEPTH; imem_req_addr = pc.
  - On handshake: capture req_pc = pc, pc <= pc + 4 (wraps modulo 2^XLEN), go to WAIT.
  - Address and valid are held stable while valid && !ready, except on redirect.
- WAIT:
  - On imem_rsp_valid: push {req_pc, imem_rsp_data} into the FIFO, return to FETCH.
  - The next request may issue in the following cycle, giving 2-cycle throughput per instruction.
- DRAIN:
  - Entered when a redirect arrives while a response is still owed.
  - The next imem_rsp_valid is discarded (not pushed), then go to FETCH.
- Redirect (highest priority):
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}; FIFO flushed the same edge.
  - In FETCH without a handshake: the request is withdrawn; the new pc is requested next cycle.
  - In FETCH with a handshake in the same cycle: the request counts as issued; go to DRAIN.
  - In WAIT with no response: go to DRAIN.
  - In WAIT with a response in the same cycle: the response is discarded; go to FETCH.
  - In DRAIN: stay in DRAIN; pc is updated.
  - Redirect plus a dec pop in the same cycle: the flush wins; the pop is a no-op.
- FIFO:
  - dec_valid = !empty; dec_pc/dec_instr come from the head entry (registered).
  - A pop happens on dec_valid && dec_ready.
  - A simultaneous push and pop when full cannot occur, because of the issue credit rule.
  - A simultaneous push and pop otherwise leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a response in cycle N appears on dec_valid in cycle N+1.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, dec_ready = 1, and an accepted response (not discarded) arrives, the response drives dec_valid/dec_pc/dec_instr combinationally in the same cycle and is not pushed. The credit rule is unchanged.
- Not defined: every response goes through the FIFO with 1-cycle latency; the decode outputs are purely registered.

Test Plan:
- Reset release, imem_req_ready = 1, 1-cycle response latency, dec_ready = 1:
  - Required: requests at 0x0, 0x4, 0x8.
  - Required: dec outputs (pc,instr) = (0x0,D0), (0x4,D1), (0x8,D2), each one cycle after its response.
- dec_ready = 0 for 10 cycles:
  - Required: exactly FIFO_DEPTH = 2 entries buffered; imem_req_valid stays 0 afterwards.
  - Required: on release, entries drain in order and fetching resumes at 0x8.
- Redirect to 0x100 while in WAIT, with the response arriving 2 cycles later:
  - Required: the stale instruction never appears on dec; the next request is 0x100; dec_pc = 0x100 next.
- Redirect to 0x203 together with imem_rsp_valid in WAIT:
  - Required: the response is dropped; the next request address is 0x200.
- Reset asserted mid-WAIT with the FIFO holding 1 entry:
  - Required: dec_valid and imem_req_valid are 0 immediately (asynchronously).
  - Required: after release, the first request is RESET_PC.
- pc = 0xFFFF_FFFC fetched:
  - Required: the next request is 0x0000_0000 (wrap-around).
